regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_ctrl.sv | 134 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback controller.
package regfile_pkg;

    localparam int DEF_WORD       = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic int pc_index(input int aw);
        return (1 << aw) - 1;
    endfunction

    localparam logic [DEF_ADDR_WIDTH-1:0] PC_ADDR = DEF_ADDR_WIDTH'(pc_index(DEF_ADDR_WIDTH));

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]         addr;
        logic [DEF_WORD*DEF_WIDTH-1:0]     data;
        logic                              branch;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-request FIFO: storage, wrapping pointers and occupancy, with a
// per-slot valid view so the parent can search the queued entries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  entry_t               entry_i,
    output entry_t               head_o,
    output logic [CW-1:0]        count_o,
    output entry_t [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]     valid_o
);

    entry_t [DEPTH-1:0] mem_q;
    logic   [PW-1:0]    rd_q;
    logic   [PW-1:0]    wr_q;
    logic   [CW-1:0]    count_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // NOTE: storage is deliberately not reset; the valid view below masks stale slots.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= entry_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = {1'b0, PW'(i) - rd_q} < count_q;
        end
    end

    assign head_o    = mem_q[rd_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: queues register writes / PC-relative branches and
// issues one per cycle. Hazard flags exist only with REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int  WORD       = DEF_WORD,
    parameter int  WIDTH      = DEF_WIDTH,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int  DEPTH      = 4,
    localparam int DW         = WORD * WIDTH,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DW-1:0]         req_data,
    input  logic                  req_branch,
    input  logic                  flush,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DW-1:0]         wd,
    output logic                  ib,
    output logic [DW-1:0]         bv,
    input  logic [ADDR_WIDTH-1:0] chk1,
    input  logic [ADDR_WIDTH-1:0] chk2,
    output logic                  busy1,
    output logic                  busy2,
    output logic [CW-1:0]         count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DW-1:0]         data;
        logic                  branch;
    } entry_t;

    entry_t               head;
    entry_t [DEPTH-1:0]   fifo_entries;
    logic   [DEPTH-1:0]   fifo_valid;
    logic                 push;
    logic                 pop;

    assign req_ready = (count < CW'(DEPTH)) && !reset;
    assign push      = req_valid && req_ready && !flush;
    assign pop       = (count != '0);

    wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push_i    (push),
        .pop_i     (pop),
        .entry_i   ('{addr: req_addr, data: req_data, branch: req_branch}),
        .head_o    (head),
        .count_o   (count),
        .entries_o (fifo_entries),
        .valid_o   (fifo_valid)
    );

    logic                  we_q, we_d;
    logic                  ib_q, ib_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DW-1:0]         wd_q, wd_d;
    logic [DW-1:0]         bv_q, bv_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        we_d = 1'b0;
        ib_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        bv_d = bv_q;
        if (pop && !flush) begin
            if (head.branch) begin
                ib_d = 1'b1;
                bv_d = head.data;
            end else begin
                we_d = 1'b1;
                wa_d = head.addr;
                wd_d = head.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= 1'b0;
            ib_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            bv_q <= '0;
        end else begin
            we_q <= we_d;
            ib_q <= ib_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
            bv_q <= bv_d;
        end
    end

    assign we = we_q;
    assign ib = ib_q;
    assign wa = wa_q;
    assign wd = wd_q;
    assign bv = bv_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic [ADDR_WIDTH-1:0] PC = ADDR_WIDTH'(pc_index(ADDR_WIDTH));

    // A branch only ever targets the PC, whatever address it carried.
    function automatic logic hit(input logic [ADDR_WIDTH-1:0] chk, input entry_t e);
        return e.branch ? (chk == PC) : (chk == e.addr);
    endfunction

    always_comb begin
        busy1 = (we_q && (wa_q == chk1)) || (ib_q && (chk1 == PC));
        busy2 = (we_q && (wa_q == chk2)) || (ib_q && (chk2 == PC));
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                busy1 = busy1 | hit(chk1, fifo_entries[i]);
                busy2 = busy2 | hit(chk2, fifo_entries[i]);
            end
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{fifo_entries, fifo_valid, chk1, chk2};
    assign busy1     = 1'b0;
    assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomised scoreboard bench for regfile_wb_ctrl against a queue-level model.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int DW    = DEF_WORD * DEF_WIDTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_branch = 1'b0;
    logic          flush = 1'b0;
    logic          we, ib, busy1, busy2;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, bv;
    logic [AW-1:0] chk1 = '0, chk2 = '0;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_branch(req_branch), .flush(flush),
        .we(we), .wa(wa), .wd(wd), .ib(ib), .bv(bv),
        .chk1(chk1), .chk2(chk2), .busy1(busy1), .busy2(busy2), .count(count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: entries waiting in the queue, entries due on the outputs
    // this cycle, and the last values each output port should hold.
    wb_entry_t     mq[$];
    wb_entry_t     expq[$];
    logic [AW-1:0] h_wa = '0;
    logic [DW-1:0] h_wd = '0;
    logic [DW-1:0] h_bv = '0;
    bit            mon_en = 1'b0;

    always @(posedge clk) begin : model
        int        sz;
        wb_entry_t e;
        sz = mq.size();
        expq.delete();
        if (reset) begin
            mq.delete();
            h_wa = '0;
            h_wd = '0;
            h_bv = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0) begin
                e = mq.pop_front();
                expq.push_back(e);
                if (e.branch) h_bv = e.data;
                else begin
                    h_wa = e.addr;
                    h_wd = e.data;
                end
            end
            if (req_valid && sz < DEPTH)
                mq.push_back('{addr: req_addr, data: req_data, branch: req_branch});
        end
    end

    function automatic bit targets(input wb_entry_t e, input logic [AW-1:0] c);
        return e.branch ? (c == PC_ADDR) : (c == e.addr);
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] c);
        bit b = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
        foreach (mq[i]) if (targets(mq[i], c)) b = 1'b1;
        if (expq.size() > 0 && targets(expq[0], c)) b = 1'b1;
`endif
        return b;
    endfunction

    always @(negedge clk) begin : monitor
        wb_entry_t e;
        if (mon_en) begin
            check("count", count, mq.size());
            check("req_ready", req_ready, (mq.size() < DEPTH) && !reset);
            check("busy1", busy1, model_busy(chk1));
            check("busy2", busy2, model_busy(chk2));
            if (we || ib) begin
                if (expq.size() == 0) begin
                    check("spurious_issue", {we, ib}, 2'b00);
                end else begin
                    e = expq.pop_front();
                    check("we", we, !e.branch);
                    check("ib", ib, e.branch);
                    if (e.branch) check("bv_issue", bv, e.data);
                    else begin
                        check("wa_issue", wa, e.addr);
                        check("wd_issue", wd, e.data);
                    end
                end
            end else if (expq.size() != 0) begin
                check("missing_issue", {we, ib}, expq[0].branch ? 2'b01 : 2'b10);
                expq.delete();
            end
            check("wa_hold", wa, h_wa);
            check("wd_hold", wd, h_wd);
            check("bv_hold", bv, h_bv);
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic b, input logic f, input logic r);
        req_valid  = v;
        req_addr   = a;
        req_data   = d;
        req_branch = b;
        flush      = f;
        reset      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;

        // single write, then observe latency and drain
        step(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        idle(3);

        // five back-to-back writes
        for (int i = 0; i < 5; i++) step(1'b1, AW'(i + 4), $urandom, 1'b0, 1'b0, 1'b0);
        idle(3);

        // branch with a non-PC address, hazard probe on the PC
        chk1 = 4'd15;
        chk2 = 4'd0;
        step(1'b1, 4'd0, 32'h10, 1'b1, 1'b0, 1'b0);
        idle(3);

        // writes to r2 and r7, probes on r2 and r5
        chk1 = 4'd2;
        chk2 = 4'd5;
        step(1'b1, 4'd2, 32'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 32'h7777, 1'b0, 1'b0, 1'b0);
        idle(3);

        // flush with requests around it
        step(1'b1, 4'd1, 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2, 32'h2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 32'h3, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd4, 32'h4, 1'b1, 1'b1, 1'b0);
        idle(3);

        // reset mid-operation, dominating flush and req_valid
        step(1'b1, 4'd6, 32'h6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 32'h8, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'd9, 32'h9, 1'b0, 1'b0, 1'b1);
        idle(3);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            chk1 = ($urandom_range(0, 3) == 0) ? 4'd15 : AW'($urandom);
            chk2 = AW'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, AW'($urandom_range(0, 3) == 0 ? 15 : $urandom),
                 $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 59) == 0);
        end
        idle(4);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
